// File: rtl/l4_acc_ctrl.sv
// l4_acc_ctrl -- sequencing controller for the layer-4 accumulation RAM
// (64 x DW, accessed as four 16-lane groups at bases 0/16/32/48).
//
// A run clears all four groups, then adds NUM_PASSES sweeps of 16-lane
// partial-sum beats into the RAM with per-lane saturating read-modify-write,
// and finally pulses done.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        run request, honoured only in IDLE
//   in_valid     partial-sum beat valid
//   in_ready     beat accepted this cycle (high throughout ACC)
//   psum         16 signed lanes, lane j -> entry base+j
//   ram_wr       RAM write enable
//   ram_addr_wr  RAM group base address {group, 4'b0000}
//   ram_din      RAM write data (zeros in CLEAR, saturated sums in ACC)
//   ram_dout_wr  combinational RAM read-back of entries base..base+15
//   busy         high in CLEAR or ACC
//   done         one-cycle completion pulse
module l4_acc_ctrl #(
    parameter int NUM_PASSES = 8,
    parameter int DW         = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0][DW-1:0]  psum,
    output logic                 ram_wr,
    output logic [5:0]           ram_addr_wr,
    output logic [15:0][DW-1:0]  ram_din,
    input  logic [15:0][DW-1:0]  ram_dout_wr,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACC,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    group;
    logic [PW-1:0] pass;
    logic          accept;

    // Signed add in DW+1 bits; disagreement of the top two bits means the
    // true sum left the DW-bit range, and the carry-out bit gives the sign.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1])
            sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat_add = s[DW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            group <= '0;
            pass  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        group <= '0;
                        pass  <= '0;
                    end
                end
                CLEAR: begin
                    // group wraps 3->0 on the last clear write, ready for ACC
                    group <= group + 2'd1;
                    if (group == 2'd3)
                        state <= ACC;
                end
                ACC: begin
                    if (accept) begin
                        group <= group + 2'd1;
                        if (group == 2'd3) begin
                            if (pass == LAST_PASS) begin
                                pass  <= '0;
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                pass <= pass + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready    = (state == ACC);
        busy        = (state == CLEAR) || (state == ACC);
        accept      = in_valid && in_ready;
        ram_wr      = (state == CLEAR) || accept;
        ram_addr_wr = {group, 4'b0000};
        ram_din     = '0;
        if (state == ACC) begin
            for (int unsigned j = 0; j < 16; j++)
                ram_din[j] = sat_add(ram_dout_wr[j], psum[j]);
        end
    end

endmodule

// File: tb/tb_l4_acc_ctrl.sv
// tb_l4_acc_ctrl -- directed self-checking bench for l4_acc_ctrl.
// Three instances share one clock and reset: index 0 runs NUM_PASSES=1,
// index 1 NUM_PASSES=2, index 2 NUM_PASSES=8. Each has its own RAM model
// (combinational read, write visible on the next cycle).
module tb_l4_acc_ctrl;

    localparam int DW = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst_n;
    logic [2:0]                   start, in_valid, in_ready, ram_wr, busy, done;
    logic [2:0][5:0]              addr;
    logic [2:0][15:0][DW-1:0]     psum, din, dout;
    logic [DW-1:0]                ram [3][64];
    logic [2:0]                   fill_en;
    logic [DW-1:0]                fill_val;

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        l4_acc_ctrl #(
            .NUM_PASSES((i == 0) ? 1 : ((i == 1) ? 2 : 8)),
            .DW(DW)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[i]),
            .in_valid   (in_valid[i]),
            .in_ready   (in_ready[i]),
            .psum       (psum[i]),
            .ram_wr     (ram_wr[i]),
            .ram_addr_wr(addr[i]),
            .ram_din    (din[i]),
            .ram_dout_wr(dout[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (fill_en[k]) begin
                for (int e = 0; e < 64; e++) ram[k][e] <= fill_val;
            end else if (ram_wr[k]) begin
                for (int j = 0; j < 16; j++) ram[k][int'(addr[k]) + j] <= din[k][j];
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 16; j++)
                dout[k][j] = ram[k][int'(addr[k]) + j];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start in the current cycle, then verify CLEAR on cycles 1-4 and
    // in_ready on cycle 5. Optionally pulses start mid-CLEAR.
    task automatic start_and_clear(input int k, input bit pulse_in_clear);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (pulse_in_clear && c == 1) start[k] = 1'b1;
            #1;
            check($sformatf("clr_wr%0d_c%0d", k, c + 1), ram_wr[k], 1);
            check($sformatf("clr_addr%0d_c%0d", k, c + 1), addr[k], 16 * c);
            check($sformatf("clr_din%0d_c%0d", k, c + 1), |din[k], 0);
            check($sformatf("clr_rdy%0d_c%0d", k, c + 1), in_ready[k], 0);
            check($sformatf("clr_busy%0d_c%0d", k, c + 1), busy[k], 1);
            @(posedge clk); #1;
            start[k] = 1'b0;
        end
        #1;
        check($sformatf("acc_rdy%0d", k), in_ready[k], 1);
        check($sformatf("acc_busy%0d", k), busy[k], 1);
    endtask

    // Feed n accepted beats of pv with an independent group model.
    task automatic run_beats(input int k, input logic [15:0][DW-1:0] pv, input int n,
                             input bit gapped, input int start_at_beat,
                             input bit finish, input bit start_in_done);
        int   acc = 0;
        int   cyc = 0;
        int   g   = 0;
        logic v;
        psum[k] = pv;
        while (acc < n && cyc < n * 8 + 16) begin
            v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid[k] = v;
            if (v && acc == start_at_beat) start[k] = 1'b1;
            #1;
            check($sformatf("beat_wr%0d", k), ram_wr[k], v);
            check($sformatf("beat_addr%0d", k), addr[k], 16 * g);
            check($sformatf("beat_rdy%0d", k), in_ready[k], 1);
            check($sformatf("beat_done%0d", k), done[k], 0);
            if (v) begin
                acc++;
                g = (g + 1) % 4;
            end
            cyc++;
            @(posedge clk); #1;
            start[k] = 1'b0;
        end
        in_valid[k] = 1'b0;
        check($sformatf("beat_count%0d", k), acc, n);
        if (finish) begin
            if (start_in_done) start[k] = 1'b1;
            #1;
            check($sformatf("done%0d", k), done[k], 1);
            check($sformatf("done_busy%0d", k), busy[k], 0);
            check($sformatf("done_rdy%0d", k), in_ready[k], 0);
            check($sformatf("done_wr%0d", k), ram_wr[k], 0);
            @(posedge clk); #1;
            start[k] = 1'b0;
            #1;
            check($sformatf("idle_done%0d", k), done[k], 0);
            check($sformatf("idle_busy%0d", k), busy[k], 0);
            check($sformatf("idle_wr%0d", k), ram_wr[k], 0);
        end
    endtask

    task automatic check_ram_const(input int k, input logic [DW-1:0] val);
        for (int e = 0; e < 64; e++)
            check($sformatf("ram%0d[%0d]", k, e), ram[k][e], val);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][DW-1:0] pv;
        logic [DW-1:0]       sin  [5];
        logic [DW-1:0]       sexp [5];

        rst_n    = 1'b0;
        start    = '0;
        in_valid = '0;
        psum     = '0;
        fill_en  = '0;
        fill_val = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy%0d", k), busy[k], 0);
            check($sformatf("rst_rdy%0d", k), in_ready[k], 0);
            check($sformatf("rst_done%0d", k), done[k], 0);
            check($sformatf("rst_wr%0d", k), ram_wr[k], 0);
            check($sformatf("rst_addr%0d", k), addr[k], 0);
            check($sformatf("rst_din%0d", k), |din[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // NUM_PASSES=1: RAM preloaded with 5, lane j = j -> entry 16g+j = j
        fill_val   = 36'd5;
        fill_en[0] = 1'b1;
        @(posedge clk); #1;
        fill_en[0] = 1'b0;
        for (int j = 0; j < 16; j++) pv[j] = DW'(j);
        start_and_clear(0, 1'b0);
        run_beats(0, pv, 4, 1'b0, -1, 1'b1, 1'b0);
        for (int e = 0; e < 64; e++)
            check($sformatf("ram0[%0d]", e), ram[0][e], DW'(e % 16));

        // NUM_PASSES=8, lanes = 1, continuous; start pulsed in CLEAR, ACC, DONE
        for (int j = 0; j < 16; j++) pv[j] = 36'd1;
        start_and_clear(2, 1'b1);
        run_beats(2, pv, 32, 1'b0, 10, 1'b1, 1'b1);
        check_ram_const(2, 36'd8);

        // Start one cycle after done, gapped valid: same final sums
        start_and_clear(2, 1'b0);
        run_beats(2, pv, 32, 1'b1, -1, 1'b1, 1'b0);
        check_ram_const(2, 36'd8);

        // Reset mid-ACC at pass=3, group=2 (14 beats in), then a fresh run
        start_and_clear(2, 1'b0);
        run_beats(2, pv, 14, 1'b0, -1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy[2], 0);
        check("midrst_rdy", in_ready[2], 0);
        check("midrst_wr", ram_wr[2], 0);
        check("midrst_addr", addr[2], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("postrst_busy", busy[2], 0);
        start_and_clear(2, 1'b0);
        run_beats(2, pv, 32, 1'b0, -1, 1'b1, 1'b0);
        check_ram_const(2, 36'd8);

        // NUM_PASSES=2 saturation and signed boundary cases
        sin[0] = 36'h7_FFFF_FFFF;  sexp[0] = 36'h7_FFFF_FFFF;
        sin[1] = 36'h8_0000_0000;  sexp[1] = 36'h8_0000_0000;
        sin[2] = 36'h4_0000_0000;  sexp[2] = 36'h7_FFFF_FFFF;
        sin[3] = 36'hC_0000_0000;  sexp[3] = 36'h8_0000_0000;
        sin[4] = 36'hF_FFFF_FFFD;  sexp[4] = 36'hF_FFFF_FFFA;
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < 16; j++) pv[j] = sin[t];
            start_and_clear(1, 1'b0);
            run_beats(1, pv, 8, 1'b0, -1, 1'b1, 1'b0);
            check_ram_const(1, sexp[t]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
